// File: rtl/fetch.sv
// rtl/fetch.sv - instruction fetch stage: sequential requests, prefetch FIFO, redirect flush
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect halts fetch and emits one fault entry.
module fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    input  logic        i_imem_rsp_err,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_fault
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int SW = CW + 1;
    localparam logic [SW-1:0] L_DEPTH = SW'(FIFO_DEPTH);

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [1:0] { BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2 } state_t;
`else
    typedef enum logic [1:0] { BOOT = 2'd0, RUN = 2'd1 } state_t;
`endif

    state_t        r_state;
    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_out_cnt;
    logic [CW-1:0] r_disc_cnt;
    logic [CW-1:0] r_f_cnt;
    logic [AW-1:0] r_pq_wr;
    logic [AW-1:0] r_pq_rd;
    logic [AW-1:0] r_f_wr;
    logic [AW-1:0] r_f_rd;
    logic [31:0]   r_pq      [FIFO_DEPTH];
    logic [31:0]   r_f_instr [FIFO_DEPTH];
    logic [31:0]   r_f_pc    [FIFO_DEPTH];
    logic          r_f_fault [FIFO_DEPTH];

    logic          w_credit;
    logic          w_accept;
    logic          w_rsp_keep;
    logic          w_pop;
    logic          w_push;
    logic [CW-1:0] w_out_next;
    logic [31:0]   w_push_instr;
    logic [31:0]   w_push_pc;
    logic          w_push_fault;

    // Outstanding plus buffered never exceeds the FIFO, so every response has a slot.
    assign w_credit         = ({1'b0, r_out_cnt} + {1'b0, r_f_cnt}) < L_DEPTH;
    assign o_imem_req_valid = (r_state == RUN) & ~i_redirect & w_credit;
    assign o_imem_addr      = r_fetch_pc;
    assign w_accept         = o_imem_req_valid & i_imem_req_ready;
    assign w_out_next       = r_out_cnt + CW'(w_accept) - CW'(i_imem_rsp_valid);
    assign w_rsp_keep       = i_imem_rsp_valid & (r_disc_cnt == '0) & ~i_redirect;
    assign o_valid          = (r_f_cnt != '0);
    assign w_pop            = o_valid & i_ready & ~i_redirect;
    assign o_instr          = r_f_instr[r_f_rd];
    assign o_pc             = r_f_pc[r_f_rd];
    assign o_fault          = r_f_fault[r_f_rd];

`ifdef FETCH_ALIGN_CHECK_EN
    logic        r_halt_pend;
    logic [31:0] r_halt_pc;
    logic        w_misalign;
    logic        w_halt_push;

    assign w_misalign   = (i_redirect_pc[1:0] != 2'b00);
    assign w_halt_push  = r_halt_pend & (r_f_cnt == '0) & ~i_redirect & ~w_rsp_keep;
    assign w_push       = w_rsp_keep | w_halt_push;
    assign w_push_instr = w_halt_push ? 32'h0000_0013 : i_imem_rsp_data;
    assign w_push_pc    = w_halt_push ? r_halt_pc : r_pq[r_pq_rd];
    assign w_push_fault = w_halt_push | i_imem_rsp_err;
`else
    assign w_push       = w_rsp_keep;
    assign w_push_instr = i_imem_rsp_data;
    assign w_push_pc    = r_pq[r_pq_rd];
    assign w_push_fault = i_imem_rsp_err;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= BOOT;
            r_fetch_pc <= RESET_PC;
            r_out_cnt  <= '0;
            r_disc_cnt <= '0;
            r_f_cnt    <= '0;
            r_pq_wr    <= '0;
            r_pq_rd    <= '0;
            r_f_wr     <= '0;
            r_f_rd     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_pq[i]      <= '0;
                r_f_instr[i] <= '0;
                r_f_pc[i]    <= '0;
                r_f_fault[i] <= 1'b0;
            end
`ifdef FETCH_ALIGN_CHECK_EN
            r_halt_pend <= 1'b0;
            r_halt_pc   <= '0;
`endif
        end else begin
            if (r_state == BOOT) begin
                r_state <= RUN;
            end
            if (w_accept) begin
                r_fetch_pc    <= r_fetch_pc + 32'd4;
                r_pq[r_pq_wr] <= r_fetch_pc;
                r_pq_wr       <= r_pq_wr + 1'b1;
            end
            // The pending-PC queue drains with every response, stale or not.
            if (i_imem_rsp_valid) begin
                r_pq_rd <= r_pq_rd + 1'b1;
            end
            r_out_cnt <= w_out_next;
            if (i_redirect) begin
                r_fetch_pc <= i_redirect_pc & 32'hFFFF_FFFC;
                r_disc_cnt <= w_out_next;
                r_f_cnt    <= '0;
                r_f_wr     <= '0;
                r_f_rd     <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
                r_halt_pc   <= i_redirect_pc;
                r_halt_pend <= w_misalign;
                r_state     <= w_misalign ? HALT : RUN;
`endif
            end else begin
                if (i_imem_rsp_valid && (r_disc_cnt != '0)) begin
                    r_disc_cnt <= r_disc_cnt - 1'b1;
                end
                if (w_push) begin
                    r_f_instr[r_f_wr] <= w_push_instr;
                    r_f_pc[r_f_wr]    <= w_push_pc;
                    r_f_fault[r_f_wr] <= w_push_fault;
                    r_f_wr            <= r_f_wr + 1'b1;
                end
                if (w_pop) begin
                    r_f_rd <= r_f_rd + 1'b1;
                end
                r_f_cnt <= r_f_cnt + CW'(w_push) - CW'(w_pop);
`ifdef FETCH_ALIGN_CHECK_EN
                if (w_halt_push) begin
                    r_halt_pend <= 1'b0;
                end
`endif
            end
        end
    end
endmodule

// File: tb/tb_fetch.sv
// tb/tb_fetch.sv - randomized bench for fetch against a sequential-stream reference model
module tb_fetch;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] addr;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        rsp_err = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        o_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        o_fault;

    always #5 clk = ~clk;

    fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .o_imem_req_valid(req_valid), .i_imem_req_ready(mem_ready), .o_imem_addr(addr),
        .i_imem_rsp_valid(rsp_valid), .i_imem_rsp_data(rsp_data), .i_imem_rsp_err(rsp_err),
        .i_redirect(redirect), .i_redirect_pc(redirect_pc),
        .o_valid(o_valid), .i_ready(dec_ready),
        .o_instr(o_instr), .o_pc(o_pc), .o_fault(o_fault)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        logic [31:0] h;
        h = a * 32'h85EB_CA6B;
        return (a == 32'h8) || (h[31:28] == 4'hF);
    endfunction

    function automatic logic [31:0] pick_tgt();
        logic [31:0] t;
        t = ($urandom_range(3) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F)) : ($urandom & 32'h0000_0FFF);
`ifdef FETCH_ALIGN_CHECK_EN
        t[1:0] = 2'b00;
`endif
        return t;
    endfunction

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t mq[$];

    int cyc = 0, lat = 1, delivered = 0;
    int pct_mrdy = 100, pct_drdy = 100, pct_redir = 0;
    logic force_redir = 1'b0, coincide = 1'b0;
    logic [31:0] force_tgt = '0, coin_tgt = '0;
    logic [31:0] exp_pc = '0, exp_req = '0, first_pc = '0;
    logic first_pend = 1'b0, halted = 1'b0, halt_seen = 1'b0;
    logic [31:0] halt_pc = '0;
    logic prev_redir = 1'b0, prev_req = 1'b0, prev_mrdy = 1'b0, prev_ov = 1'b0, prev_drdy = 1'b0;
    logic [31:0] prev_addr = '0, prev_pc = '0, prev_instr = '0;

    task automatic deliver();
        if (halted) begin
            check_eq("halt_once", halt_seen, 1'b0);
            check_eq("halt_pc", o_pc, halt_pc);
            check_eq("halt_instr", o_instr, 32'h0000_0013);
            check_eq("halt_fault", o_fault, 1'b1);
            halt_seen = 1'b1;
        end else begin
            check_eq("pc", o_pc, exp_pc);
            check_eq("instr", o_instr, mem_word(exp_pc));
            check_eq("fault", o_fault, mem_err(exp_pc));
            exp_pc += 32'd4;
        end
        if (first_pend) begin
            first_pc   = o_pc;
            first_pend = 1'b0;
        end
        delivered++;
    endtask

    task automatic step();
        logic        redir;
        logic [31:0] tgt;
        mreq_t       e;
        @(negedge clk);
        cyc++;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = mem_word(mq[0].addr);
            rsp_err   = mem_err(mq[0].addr);
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = $urandom;
            rsp_err   = 1'b0;
        end
        mem_ready = ($urandom_range(99) < pct_mrdy);
        dec_ready = ($urandom_range(99) < pct_drdy);
        redir     = ($urandom_range(999) < pct_redir);
        tgt       = pick_tgt();
        if (coincide && rsp_valid && o_valid && dec_ready) begin
            redir = 1'b1; tgt = coin_tgt; coincide = 1'b0;
        end
        if (force_redir) begin
            redir = 1'b1; tgt = force_tgt; force_redir = 1'b0;
        end
        redirect    = redir;
        redirect_pc = tgt;
        #1;
        if (prev_redir) check_eq("flush", o_valid, 1'b0);
        if (prev_req && !prev_mrdy && !prev_redir && !redir) begin
            check_eq("req_hold_v", req_valid, 1'b1);
            check_eq("req_hold_a", addr, prev_addr);
        end
        if (prev_ov && !prev_drdy && !prev_redir) begin
            check_eq("out_hold_v", o_valid, 1'b1);
            check_eq("out_hold_pc", o_pc, prev_pc);
            check_eq("out_hold_instr", o_instr, prev_instr);
        end
        check_eq("credit", mq.size() <= DEPTH, 1'b1);
        if (redir || halted) check_eq("no_req", req_valid, 1'b0);
        if (req_valid && mem_ready) begin
            check_eq("req_addr", addr, exp_req);
            e.addr = addr;
            e.due  = cyc + lat;
            if (mq.size() > 0 && mq[$].due > e.due) e.due = mq[$].due;
            mq.push_back(e);
            exp_req += 32'd4;
        end
        if (rsp_valid) void'(mq.pop_front());
        if (o_valid && dec_ready && !redir) deliver();
        if (redir) begin
            exp_pc     = tgt & 32'hFFFF_FFFC;
            exp_req    = exp_pc;
            first_pend = 1'b1;
            halted     = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            if (tgt[1:0] != 2'b00) begin
                halted = 1'b1; halt_pc = tgt; halt_seen = 1'b0;
            end
`endif
        end
        prev_redir = redir;     prev_req  = req_valid; prev_mrdy  = mem_ready; prev_addr = addr;
        prev_ov    = o_valid;   prev_drdy = dec_ready; prev_pc    = o_pc;      prev_instr = o_instr;
    endtask

    initial begin
        int k, d0;
        repeat (3) @(negedge clk);
        check_eq("rst_o_valid", o_valid, 1'b0);
        check_eq("rst_req_valid", req_valid, 1'b0);
        check_eq("rst_o_instr", o_instr, 32'h0);
        check_eq("rst_o_pc", o_pc, 32'h0);
        check_eq("rst_o_fault", o_fault, 1'b0);
        rst_n = 1'b1;

        k = 0;
        do begin step(); k++; end while (!o_valid && k < 20);
        check_eq("first_valid_cycle", k, 3);
        d0 = delivered;
        repeat (20) step();
        check_eq("progress_zero_wait", delivered > d0 + 4, 1'b1);

        pct_drdy = 0;
        d0 = delivered;
        repeat (10) step();
        check_eq("stall_no_delivery", delivered, d0);
        pct_drdy = 100;
        repeat (10) step();
        check_eq("stall_release", delivered > d0, 1'b1);

        lat = 3;
        k = 0;
        while (mq.size() < 2 && k < 30) begin step(); k++; end
        check_eq("two_outstanding", mq.size(), 2);
        force_tgt = 32'h100; force_redir = 1'b1;
        repeat (25) step();
        check_eq("redir_first_pc", first_pc, 32'h100);
        check_eq("redir_second", exp_pc >= 32'h108, 1'b1);

        lat = 1; coin_tgt = 32'h40; coincide = 1'b1;
        repeat (30) step();
        check_eq("coincide_hit", coincide, 1'b0);
        check_eq("coincide_first_pc", first_pc, 32'h40);

        pct_mrdy = 70; pct_drdy = 70; pct_redir = 20;
        for (int blk = 0; blk < 30; blk++) begin
            lat = $urandom_range(3, 1);
            d0 = delivered;
            repeat (100) step();
            check_eq("rand_progress", delivered > d0, 1'b1);
        end
        pct_redir = 0;

`ifdef FETCH_ALIGN_CHECK_EN
        pct_mrdy = 100; pct_drdy = 100; lat = 1;
        force_tgt = 32'h102; force_redir = 1'b1;
        repeat (15) step();
        check_eq("halt_entry_seen", halt_seen, 1'b1);
        check_eq("halt_first_pc", first_pc, 32'h102);
        force_tgt = 32'h200; force_redir = 1'b1;
        repeat (15) step();
        check_eq("resume_first_pc", first_pc, 32'h200);
`endif

        pct_mrdy = 100; pct_drdy = 100; lat = 1;
        d0 = delivered;
        repeat (20) step();
        check_eq("drain_progress", delivered > d0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
